// File: rtl/way_age_tracker.sv
// Per-set, per-way valid/age store feeding the replacement victim picker.
// Optional macro AGE_GLOBAL_TICK_EN adds an age_tick input that ages every valid way.
module way_age_tracker #(
    parameter int unsigned N_WAYS   = 2,
    parameter int unsigned N_POW    = 4,
    parameter int unsigned N_SETS   = 16,
    parameter int unsigned SET_BITS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           lookup_en,
    input  logic [SET_BITS-1:0]            lookup_set,
    output logic [N_WAYS-1:0]              line_empty,
    output logic [N_WAYS-1:0][15:0]        line_age,
    output logic                           lookup_vld,
    input  logic                           acc_en,
    input  logic [1:0]                     acc_op,
    input  logic [SET_BITS-1:0]            acc_set,
    input  logic [N_POW-1:0]               acc_way,
    input  logic                           flush_req,
`ifdef AGE_GLOBAL_TICK_EN
    input  logic                           age_tick,
`endif
    output logic                           busy
);

    localparam int unsigned AGE_W = 16;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [1:0] OP_INVAL = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                                  state;
    logic [SET_BITS-1:0]                     sweep_cnt;
    logic [N_SETS-1:0][N_WAYS-1:0]           valid;
    logic [N_SETS-1:0][N_WAYS-1:0][AGE_W-1:0] age;
    logic [N_SETS-1:0][N_WAYS-1:0]           valid_d;
    logic [N_SETS-1:0][N_WAYS-1:0][AGE_W-1:0] age_d;
    logic                                    acc_ok_c;
    logic                                    tick_c;

    assign acc_ok_c = acc_en && !busy && (acc_op != OP_RSVD) && (acc_way < N_POW'(N_WAYS));

`ifdef AGE_GLOBAL_TICK_EN
    assign tick_c = age_tick && !busy;
`else
    assign tick_c = 1'b0;
`endif

    // Next array state: accessed way resets, peers in the set (or all ways on a tick) age once
    always_comb begin
        valid_d = valid;
        age_d   = age;
        for (int unsigned s = 0; s < N_SETS; s++) begin
            for (int unsigned w = 0; w < N_WAYS; w++) begin
                if (acc_ok_c && acc_set == SET_BITS'(s) && acc_way == N_POW'(w)) begin
                    valid_d[s][w] = (acc_op != OP_INVAL);
                    age_d[s][w]   = '0;
                end else if (valid[s][w] && age[s][w] != AGE_MAX &&
                             (tick_c || (acc_ok_c && acc_set == SET_BITS'(s) &&
                                         acc_op != OP_INVAL))) begin
                    age_d[s][w] = age[s][w] + AGE_W'(1);
                end
            end
        end
        if (busy) begin
            valid_d[sweep_cnt] = '0;
            age_d[sweep_cnt]   = '0;
        end
    end

    // Array, lookup port and flush sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            sweep_cnt  <= '0;
            valid      <= '0;
            age        <= '0;
            lookup_vld <= 1'b0;
            line_empty <= '1;
            line_age   <= '0;
        end else begin
            valid      <= valid_d;
            age        <= age_d;
            lookup_vld <= lookup_en;
            if (lookup_en) begin
                line_empty <= ~valid[lookup_set];
                line_age   <= age[lookup_set];
            end
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state     <= FLUSH;
                        busy      <= 1'b1;
                        sweep_cnt <= '0;
                    end
                end
                FLUSH: begin
                    if (sweep_cnt == SET_BITS'(N_SETS - 1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        sweep_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + SET_BITS'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
